// File: rtl/fc_inference_sequencer.sv
// Start/done sequencer for the FC1/FC2/FC3 + ReLU + argmax classifier datapath.
// Sweeps the shared weight address, drives the layer/ReLU strobes and latches the argmax result.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | address all-ones, layer and ReLU held in reset, ready=1
//   S_STREAM | address 0..INPUT_NODES-1, accumulators running
//   S_DRAIN  | address keeps counting for DRAIN_CYCLES (read latency, last MAC)
//   S_RELU   | single en_relu cycle, address held
//   S_SETTLE | SETTLE_CYCLES wait for the argmax to settle
//   S_DONE   | done pulse; class_out and frame_count updated on entry
module fc_inference_sequencer #(
  parameter int INPUT_NODES   = 400,
  parameter int ADDR_WIDTH    = 9,
  parameter int DRAIN_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  auto_run,
  input  logic [3:0]            class_in,
  output logic                  ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  rst_layer,
  output logic                  rst_relu,
  output logic                  en_relu,
  output logic                  done,
  output logic [3:0]            class_out,
  output logic [15:0]           frame_count
);

  localparam int TIMER_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int TIMER_W   = (TIMER_MAX < 2) ? 1 : $clog2(TIMER_MAX);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(INPUT_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_RELU,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [ADDR_WIDTH-1:0] address_d;
  logic                rst_layer_d, rst_relu_d, en_relu_d, done_d;
  logic [3:0]          class_out_d;
  logic [15:0]         frame_count_d;

  // Every output is the registered image of the value computed for the next state.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    address_d     = address;
    rst_layer_d   = 1'b0;
    rst_relu_d    = 1'b0;
    en_relu_d     = 1'b0;
    done_d        = 1'b0;
    class_out_d   = class_out;
    frame_count_d = frame_count;

    case (state_q)
      S_IDLE: begin
        if (start || auto_run) begin
          state_d   = S_STREAM;
          address_d = '0;
        end else begin
          address_d   = '1;
          rst_layer_d = 1'b1;
          rst_relu_d  = 1'b1;
        end
      end

      S_STREAM: begin
        address_d = address + 1'b1;
        if (address == LAST_ADDR) begin
          state_d = S_DRAIN;
          timer_d = TIMER_W'(DRAIN_CYCLES - 1);
        end
      end

      S_DRAIN: begin
        if (timer_q == '0) begin
          state_d   = S_RELU;
          en_relu_d = 1'b1;
        end else begin
          timer_d   = timer_q - 1'b1;
          address_d = address + 1'b1;
        end
      end

      S_RELU: begin
        state_d = S_SETTLE;
        timer_d = TIMER_W'(SETTLE_CYCLES - 1);
      end

      S_SETTLE: begin
        if (timer_q == '0) begin
          state_d       = S_DONE;
          done_d        = 1'b1;
          class_out_d   = class_in;
          frame_count_d = frame_count + 16'd1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d     = S_IDLE;
        address_d   = '1;
        rst_layer_d = 1'b1;
        rst_relu_d  = 1'b1;
      end

      default: begin
        state_d     = S_IDLE;
        address_d   = '1;
        rst_layer_d = 1'b1;
        rst_relu_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      address     <= '1;
      rst_layer   <= 1'b1;
      rst_relu    <= 1'b1;
      en_relu     <= 1'b0;
      done        <= 1'b0;
      class_out   <= 4'd0;
      frame_count <= 16'd0;
      ready       <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      address     <= address_d;
      rst_layer   <= rst_layer_d;
      rst_relu    <= rst_relu_d;
      en_relu     <= en_relu_d;
      done        <= done_d;
      class_out   <= class_out_d;
      frame_count <= frame_count_d;
      ready       <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_fc_inference_sequencer.sv
// Directed-plus-random bench for fc_inference_sequencer; expectations come from a
// cycle-offset model of one inference measured from its launch edge.
module tb_fc_inference_sequencer;

  localparam int N  = 400;
  localparam int AW = 9;
  localparam int D  = 2;
  localparam int S  = 2;
  // offset (in cycles after the launch edge) of the done cycle, and auto_run period
  localparam int DONE_K = N + D + 1 + S;
  localparam int PERIOD = DONE_K + 2;

  logic          clk = 1'b0;
  logic          reset, start, auto_run;
  logic [3:0]    class_in;
  logic          ready, busy, rst_layer, rst_relu, en_relu, done;
  logic [AW-1:0] address;
  logic [3:0]    class_out;
  logic [15:0]   frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int prev_done_cyc = -1;
  logic [3:0]  model_class;
  logic [15:0] model_count;

  fc_inference_sequencer #(
    .INPUT_NODES(N), .ADDR_WIDTH(AW), .DRAIN_CYCLES(D), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .auto_run(auto_run), .class_in(class_in),
    .ready(ready), .busy(busy), .address(address), .rst_layer(rst_layer),
    .rst_relu(rst_relu), .en_relu(en_relu), .done(done), .class_out(class_out),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({address, rst_layer, rst_relu, en_relu, done, ready, busy});
  endfunction

  function automatic logic [31:0] idle_vec();
    logic [AW-1:0] all_ones = '1;
    return 32'({all_ones, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_outs"}, outs(), idle_vec());
    chk({tag, "_class"}, 32'(class_out), 32'(model_class));
    chk({tag, "_count"}, 32'(frame_count), 32'(model_count));
  endtask

  // Follows one inference from the cycle after its launch edge (k=0) to the IDLE cycle
  // after done (k=DONE_K+1). Negative poke/drop/reset offsets disable that action.
  task automatic watch_run(input logic [3:0] cls, input int poke_k, input int drop_auto_k,
                           input int reset_k, input bit chk_period);
    logic [AW-1:0] exp_addr;
    for (int k = 0; k <= DONE_K + 1; k++) begin
      @(negedge clk);
      if (k == DONE_K) begin
        model_class = cls;
        model_count = model_count + 16'd1;
        if (chk_period && prev_done_cyc >= 0)
          chk("done_period", 32'(cyc - prev_done_cyc), 32'(PERIOD));
        prev_done_cyc = cyc;
      end
      if (k == DONE_K + 1) begin
        chk_idle("post_run_idle");
      end else begin
        exp_addr = (k < N + D) ? AW'(k) : AW'(N + D - 1);
        chk($sformatf("run_k%0d", k), outs(),
            32'({exp_addr, 1'b0, 1'b0, (k == N + D), (k == DONE_K), 1'b0, 1'b1}));
        chk("run_class", 32'(class_out), 32'(model_class));
        chk("run_count", 32'(frame_count), 32'(model_count));
      end
      if (k == reset_k) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_class = 4'd0;
        model_count = 16'd0;
        chk_idle("mid_run_reset");
        @(negedge clk);
        chk_idle("after_reset_idle");
        return;
      end
      start    = (k == poke_k);
      if (k == drop_auto_k) auto_run = 1'b0;
      class_in = (k == DONE_K - 1) ? cls : 4'($urandom);
    end
  endtask

  initial begin
    logic [3:0] c;
    reset = 1'b1; start = 1'b0; auto_run = 1'b0; class_in = 4'd0;
    model_class = 4'd0; model_count = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");
    repeat (3) @(negedge clk);
    chk_idle("idle_hold");

    // single inference, class 7
    start = 1'b1;
    watch_run(4'd7, -1, -1, -1, 1'b0);

    // start re-pulsed mid-sweep is ignored
    start = 1'b1;
    watch_run(4'($urandom), 100, -1, -1, 1'b0);
    start = 1'b1;
    watch_run(4'($urandom), int'($urandom_range(1, N + D + S)), -1, -1, 1'b0);
    repeat (4) @(negedge clk);
    chk_idle("no_queued_start");

    // auto_run for three back-to-back runs, dropped during the third
    auto_run = 1'b1;
    prev_done_cyc = -1;
    watch_run(4'($urandom), -1, -1, -1, 1'b1);
    watch_run(4'($urandom), -1, -1, -1, 1'b1);
    c = 4'($urandom);
    watch_run(c, -1, 50, -1, 1'b1);
    repeat (5) @(negedge clk);
    chk_idle("auto_stopped");

    // start and auto_run together: exactly one launch
    start = 1'b1;
    auto_run = 1'b1;
    watch_run(4'($urandom), -1, 10, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk_idle("single_launch");

    // reset in the middle of the sweep
    start = 1'b1;
    watch_run(4'($urandom), -1, -1, 250, 1'b0);
    repeat (3) @(negedge clk);
    chk_idle("reset_no_done");

    // frame_count wrap
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    model_count = 16'hFFFF;
    @(negedge clk);
    chk_idle("preload");
    start = 1'b1;
    watch_run(4'($urandom), -1, -1, -1, 1'b0);
    chk("wrap_count", 32'(frame_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
